// File: rtl/bus_arbiter_pkg.sv
// Shared constants for the system bus arbiter: master indices and FSM states.
package bus_arbiter_pkg;

    localparam int BUS_M_FETCH = 0;
    localparam int BUS_M_LSU   = 1;
    localparam int BUS_M_DBG   = 2;

    typedef enum logic {
        BUS_ST_IDLE = 1'b0,
        BUS_ST_BUSY = 1'b1
    } bus_state_t;

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first eligible master at or above rr_ptr, wrapping.
module bus_arb_rr_pick #(
    parameter int NUM_M = 3,
    parameter int IDX_W = 2
) (
    input  logic [NUM_M-1:0] eligible,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic [NUM_M-1:0] winner,
    output logic [IDX_W-1:0] winner_idx,
    output logic             valid
);

    int               idx;
    logic [IDX_W-1:0] idx_sel;

    always_comb begin
        winner     = '0;
        winner_idx = '0;
        valid      = 1'b0;
        idx        = 0;
        idx_sel    = '0;
        for (int k = 0; k < NUM_M; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_M) begin
                idx = idx - NUM_M;
            end
            idx_sel = IDX_W'(idx);
            if (!valid && eligible[idx_sel]) begin
                valid           = 1'b1;
                winner[idx_sel] = 1'b1;
                winner_idx      = idx_sel;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter sharing the memory bus between fetch, load/store and debug,
// one transaction at a time, with a wait-state timeout and a core hold flag.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int NUM_M    = 3,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 15
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_M-1:0]        m_req_in,
    input  logic [NUM_M*ADDR_W-1:0] m_addr_in,
    input  logic [NUM_M*DATA_W-1:0] m_data_in,
    input  logic [NUM_M-1:0]        m_rw_in,
    output logic [NUM_M-1:0]        m_gnt_out,
    output logic [NUM_M-1:0]        m_ack_out,
    output logic [DATA_W-1:0]       m_data_out,
    output logic                    err_out,
    output logic                    s_req_out,
    output logic [ADDR_W-1:0]       s_addr_out,
    output logic [DATA_W-1:0]       s_data_out,
    output logic                    s_rw_out,
    input  logic [DATA_W-1:0]       s_data_in,
    input  logic                    s_ready_in,
    output logic                    hold_flag_out
);

    localparam int IDX_W = (NUM_M > 1) ? $clog2(NUM_M) : 1;
    localparam logic [7:0] LAST_WAIT = 8'(MAX_WAIT - 1);

    bus_state_t       state;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] gnt_idx;
    logic [7:0]       wait_cnt;

    logic [NUM_M-1:0] eligible;
    logic [NUM_M-1:0] pick;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_valid;
    logic [IDX_W-1:0] next_ptr;

    // The registered ack doubles as the one-cycle mask that stops the master
    // just served from winning again while its request is still high.
    assign eligible = m_req_in & ~m_ack_out;
    assign next_ptr = (gnt_idx == IDX_W'(NUM_M - 1)) ? '0 : gnt_idx + 1'b1;

    bus_arb_rr_pick #(
        .NUM_M (NUM_M),
        .IDX_W (IDX_W)
    ) u_pick (
        .eligible   (eligible),
        .rr_ptr     (rr_ptr),
        .winner     (pick),
        .winner_idx (pick_idx),
        .valid      (pick_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= BUS_ST_IDLE;
            m_gnt_out  <= '0;
            gnt_idx    <= '0;
            rr_ptr     <= '0;
            wait_cnt   <= '0;
            m_ack_out  <= '0;
            m_data_out <= '0;
            err_out    <= 1'b0;
        end else begin
            m_ack_out <= '0;
            err_out   <= 1'b0;
            case (state)
                BUS_ST_IDLE: begin
                    if (pick_valid) begin
                        state     <= BUS_ST_BUSY;
                        m_gnt_out <= pick;
                        gnt_idx   <= pick_idx;
                        wait_cnt  <= '0;
                    end
                end
                BUS_ST_BUSY: begin
                    // A ready slave beats a simultaneous timeout.
                    if (s_ready_in || (wait_cnt == LAST_WAIT)) begin
                        state      <= BUS_ST_IDLE;
                        m_ack_out  <= m_gnt_out;
                        m_data_out <= s_ready_in ? s_data_in : '0;
                        err_out    <= ~s_ready_in;
                        m_gnt_out  <= '0;
                        rr_ptr     <= next_ptr;
                        wait_cnt   <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: state <= BUS_ST_IDLE;
            endcase
        end
    end

    assign s_req_out = (state == BUS_ST_BUSY);

    always_comb begin
        s_addr_out = '0;
        s_data_out = '0;
        s_rw_out   = 1'b0;
        for (int i = 0; i < NUM_M; i++) begin
            if (m_gnt_out[i]) begin
                s_addr_out = m_addr_in[i*ADDR_W +: ADDR_W];
                s_data_out = m_data_in[i*DATA_W +: DATA_W];
                s_rw_out   = m_rw_in[i];
            end
        end
    end

    assign hold_flag_out = |(m_req_in[BUS_M_LSU:BUS_M_FETCH] & ~m_ack_out[BUS_M_LSU:BUS_M_FETCH]);

endmodule
